// File: rtl/lcd_rgb_tx_if.sv
// Pixel-source and LCD-pin bundle of the RGB LCD transmitter.
// master = transmitter side, slave = frame source / pin side.
interface lcd_rgb_tx_if;
    logic        pixel_req;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        frame_start;
    logic [23:0] pixel_data;
    logic        rgb_oe;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;

    modport master (
        output pixel_req, pixel_x, pixel_y, frame_start,
        output rgb_oe, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        input  pixel_data
    );

    modport slave (
        input  pixel_req, pixel_x, pixel_y, frame_start,
        input  rgb_oe, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        output pixel_data
    );
endinterface

// File: rtl/lcd_rgb_tx.sv
// RGB LCD transmitter: releases the bus while the panel ID is strapped, latches the
// timing set for that ID, then generates HS/VS/DE and pixel requests.
// Optional build macro LCD_TEST_PATTERN_EN replaces source pixels with an x/y pattern.
module lcd_rgb_tx #(
    parameter int unsigned ID_WAIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  id,
    output logic         fault,
    lcd_rgb_tx_if.master bus
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Decode-ready timing: window edges and last counter value per axis
    typedef struct packed {
        logic [10:0] hsw;
        logic [10:0] hstart;
        logic [10:0] hend;
        logic [10:0] hlast;
        logic [10:0] vsw;
        logic [10:0] vstart;
        logic [10:0] vend;
        logic [10:0] vlast;
    } timing_t;

    localparam logic [15:0] WAIT_LAST = 16'(ID_WAIT - 1);

    function automatic logic id_supported(input logic [15:0] pid);
        logic ok;
        case (pid)
            16'h4342, 16'h7084, 16'h4384, 16'h7016, 16'h1018: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic timing_t timing_lookup(input logic [15:0] pid);
        timing_t     t;
        logic [10:0] hsw, hbp, hact, htot, vsw, vbp, vact, vtot;
        case (pid)
            16'h4342: begin
                hsw = 11'd41;  hbp = 11'd2;   hact = 11'd480;  htot = 11'd525;
                vsw = 11'd10;  vbp = 11'd2;   vact = 11'd272;  vtot = 11'd286;
            end
            16'h7084, 16'h4384: begin
                hsw = 11'd128; hbp = 11'd88;  hact = 11'd800;  htot = 11'd1056;
                vsw = 11'd2;   vbp = 11'd33;  vact = 11'd480;  vtot = 11'd525;
            end
            16'h7016, 16'h1018: begin
                hsw = 11'd20;  hbp = 11'd140; hact = 11'd1024; htot = 11'd1344;
                vsw = 11'd3;   vbp = 11'd20;  vact = 11'd600;  vtot = 11'd635;
            end
            default: begin
                hsw = 11'd0;   hbp = 11'd0;   hact = 11'd0;    htot = 11'd1;
                vsw = 11'd0;   vbp = 11'd0;   vact = 11'd0;    vtot = 11'd1;
            end
        endcase
        t.hsw    = hsw;
        t.hstart = hsw + hbp;
        t.hend   = hsw + hbp + hact;
        t.hlast  = htot - 11'd1;
        t.vsw    = vsw;
        t.vstart = vsw + vbp;
        t.vend   = vsw + vbp + vact;
        t.vlast  = vtot - 11'd1;
        return t;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [15:0] wait_cnt_r;
    timing_t     tmg_r;
    logic [10:0] h_cnt_r, v_cnt_r;
    logic        rgb_oe_r, fault_r;
    logic        rgb_oe_nxt_s, fault_nxt_s, run_s;
    logic        active_s, hs_s, vs_s, fs_s;
    logic [10:0] x_s, y_s;
    logic        pixel_req_r, frame_start_r, de1_r, hs1_r, vs1_r;
    logic [10:0] pixel_x_r, pixel_y_r;
    logic        de2_r, hs2_r, vs2_r;
    logic        lcd_de_r, lcd_hs_r, lcd_vs_r;
    logic [23:0] lcd_rgb_r, rgb_src_s;
`ifdef LCD_TEST_PATTERN_EN
    logic [7:0]  x2_r, y2_r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_WAIT;
        else     state_r <= state_nxt_s;
    end

    // Next-state logic; RUN and FAULT are only left through rst
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) state_nxt_s = ST_CHECK;
                else                         state_nxt_s = ST_WAIT;
            end
            ST_CHECK: begin
                if (id_supported(id)) state_nxt_s = ST_RUN;
                else                  state_nxt_s = ST_FAULT;
            end
            ST_RUN:   state_nxt_s = ST_RUN;
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_WAIT;
        endcase
    end

    // FSM outputs, registered from the next state so rgb_oe rises in the first RUN cycle
    always_comb begin
        rgb_oe_nxt_s = (state_nxt_s == ST_RUN);
        fault_nxt_s  = (state_nxt_s == ST_FAULT);
        run_s        = (state_r == ST_RUN);
    end

    // Control output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_oe_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            rgb_oe_r <= rgb_oe_nxt_s;
            fault_r  <= fault_nxt_s;
        end
    end

    // Bus-release wait counter
    always_ff @(posedge clk) begin
        if (rst)                        wait_cnt_r <= 16'd0;
        else if (state_r == ST_WAIT)    wait_cnt_r <= wait_cnt_r + 16'd1;
        else                            wait_cnt_r <= 16'd0;
    end

    // Timing set is captured once in CHECK; later id changes have no effect
    always_ff @(posedge clk) begin
        if (rst)                      tmg_r <= '0;
        else if (state_r == ST_CHECK) tmg_r <= timing_lookup(id);
        else                          tmg_r <= tmg_r;
    end

    // Raster counters, held at zero outside RUN so the first RUN cycle starts at (0,0)
    always_ff @(posedge clk) begin
        if (rst || !run_s) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 11'd0;
        end else if (h_cnt_r == tmg_r.hlast) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= (v_cnt_r == tmg_r.vlast) ? 11'd0 : v_cnt_r + 11'd1;
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Counter-stage decode
    always_comb begin
        active_s = run_s
                 && (h_cnt_r >= tmg_r.hstart) && (h_cnt_r < tmg_r.hend)
                 && (v_cnt_r >= tmg_r.vstart) && (v_cnt_r < tmg_r.vend);
        hs_s     = run_s ? !(h_cnt_r < tmg_r.hsw) : 1'b1;
        vs_s     = run_s ? !(v_cnt_r < tmg_r.vsw) : 1'b1;
        fs_s     = run_s && (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
        if (active_s) begin
            x_s = h_cnt_r - tmg_r.hstart;
            y_s = v_cnt_r - tmg_r.vstart;
        end else begin
            x_s = 11'd0;
            y_s = 11'd0;
        end
    end

    // Stage 1: request side, visible to the frame source in cycle N
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_req_r   <= 1'b0;
            pixel_x_r     <= 11'd0;
            pixel_y_r     <= 11'd0;
            frame_start_r <= 1'b0;
            de1_r         <= 1'b0;
            hs1_r         <= 1'b1;
            vs1_r         <= 1'b1;
        end else begin
`ifdef LCD_TEST_PATTERN_EN
            pixel_req_r   <= 1'b0;
`else
            pixel_req_r   <= active_s;
`endif
            pixel_x_r     <= x_s;
            pixel_y_r     <= y_s;
            frame_start_r <= fs_s;
            de1_r         <= active_s;
            hs1_r         <= hs_s;
            vs1_r         <= vs_s;
        end
    end

    // Stage 2: hold syncs/DE while the source answers the request
    always_ff @(posedge clk) begin
        if (rst) begin
            de2_r <= 1'b0;
            hs2_r <= 1'b1;
            vs2_r <= 1'b1;
`ifdef LCD_TEST_PATTERN_EN
            x2_r  <= 8'd0;
            y2_r  <= 8'd0;
`endif
        end else begin
            de2_r <= de1_r;
            hs2_r <= hs1_r;
            vs2_r <= vs1_r;
`ifdef LCD_TEST_PATTERN_EN
            x2_r  <= pixel_x_r[7:0];
            y2_r  <= pixel_y_r[7:0];
`endif
        end
    end

    // Pixel source selection: test pattern or the frame source answer
    always_comb begin
`ifdef LCD_TEST_PATTERN_EN
        rgb_src_s = {x2_r, y2_r, x2_r ^ y2_r};
`else
        rgb_src_s = bus.pixel_data;
`endif
    end

    // Pin stage: RGB, DE and syncs change together; RGB blanked outside DE
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_de_r  <= 1'b0;
            lcd_hs_r  <= 1'b1;
            lcd_vs_r  <= 1'b1;
            lcd_rgb_r <= 24'd0;
        end else begin
            lcd_de_r  <= de2_r;
            lcd_hs_r  <= hs2_r;
            lcd_vs_r  <= vs2_r;
            lcd_rgb_r <= de2_r ? rgb_src_s : 24'd0;
        end
    end

    assign bus.pixel_req   = pixel_req_r;
    assign bus.pixel_x     = pixel_x_r;
    assign bus.pixel_y     = pixel_y_r;
    assign bus.frame_start = frame_start_r;
    assign bus.rgb_oe      = rgb_oe_r;
    assign bus.lcd_hs      = lcd_hs_r;
    assign bus.lcd_vs      = lcd_vs_r;
    assign bus.lcd_de      = lcd_de_r;
    assign bus.lcd_rgb     = lcd_rgb_r;
    assign fault           = fault_r;

endmodule

// File: doc/lcd_rgb_tx.md
# lcd_rgb_tx

Drive side of the RGB LCD port: the transmitter at the other end of the panel-ID read. Holds the shared RGB bus released while the panel's strapped ID is read. Then it latches the decoded 16-bit panel ID, selects the matching timing set and generates HS/VS/DE with a pixel-request interface to the frame source. It sits between the ID reader / frame buffer and the LCD pins.

## Interface
- ID_WAIT, 16: cycles the bus stays released after reset before the ID is latched (min 2).
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- id  in  16  decoded panel ID (0x0000 = unknown).
- pixel_data  in  24  {R,G,B} for the last request, valid the cycle after pixel_req.
- pixel_req  out  1  request for pixel (pixel_x, pixel_y).
- pixel_x, pixel_y  out  11 each  coordinate of the requested pixel.
- frame_start  out  1  one-cycle pulse, first counter cycle of each frame.
- rgb_oe  out  1  1 = drive lcd_rgb onto pins; 0 = bus released for ID read.
- lcd_hs, lcd_vs  out  1 each  syncs, active-low.
- lcd_de  out  1  data enable, active-high.
- lcd_rgb  out  24  pixel bus.
- fault  out  1  sticky: ID unsupported.

## Operation
- States: WAIT → CHECK → RUN, or CHECK → FAULT. RUN and FAULT exit only via rst.
- WAIT: rgb_oe=0; counts 0..ID_WAIT-1, then CHECK.
- CHECK (1 cycle): latch the timing set for id. Later id changes are ignored.
- Timing sets, given as sync/back porch/active/front porch:
  - 0x4342: H 41/2/480/2 (525), V 10/2/272/2 (286).
  - 0x7084, 0x4384: H 128/88/800/40 (1056), V 2/33/480/10 (525).
  - 0x7016, 0x1018: H 20/140/1024/160 (1344), V 3/20/600/12 (635).
  - Any other id, including 0x0000 → FAULT.
- FAULT: fault=1, rgb_oe=0, outputs stay at reset values.
- RUN: rgb_oe=1. Counters:
  - h_cnt runs 0..HTOT-1 and wraps to 0.
  - v_cnt increments on each h wrap and wraps 0 after VTOT-1.
  - Both counters are 0 in the first RUN cycle.
- Counter-stage decode:
  - hs_n = !(h_cnt < HSW); vs_n = !(v_cnt < VSW).
  - active = h_cnt in [HSW+HBP, HSW+HBP+HACT) and v_cnt in [VSW+VBP, VSW+VBP+VACT).
  - pixel_req = active; pixel_x = h_cnt-(HSW+HBP); pixel_y = v_cnt-(VSW+VBP).
  - pixel_x/pixel_y read 0 when not active.
  - frame_start = (h_cnt==0 && v_cnt==0).
- All arithmetic is 11-bit unsigned; no value exceeds 1343.

## Timing
- Reset values of every output:
  - lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0.
  - rgb_oe=0, pixel_req=0, pixel_x=0, pixel_y=0.
  - frame_start=0, fault=0.
- rst asserted mid-frame: the next cycle shows reset values and the state returns to WAIT. The ID is re-latched after ID_WAIT cycles.
- Pipeline:
  - pixel_req/pixel_x/pixel_y/frame_start are registered from the counter stage and appear in cycle N.
  - pixel_data is sampled at the end of cycle N+1.
  - lcd_rgb, lcd_de, lcd_hs and lcd_vs all appear together in cycle N+2 (sync delayed two stages to stay aligned).
- lcd_rgb=0 whenever lcd_de=0.
- Timing from reset release:
  - rst deasserted before edge 0 → CHECK after ID_WAIT cycles.
  - RUN is entered the cycle after CHECK; rgb_oe rises in that cycle.
  - First frame_start comes one cycle after RUN entry.
- No handshake back-pressure: the source must answer every request.

## Configuration
- LCD_TEST_PATTERN_EN defined:
  - lcd_rgb = {pixel_x[7:0], pixel_y[7:0], pixel_x[7:0]^pixel_y[7:0]}, taken from the pipelined coordinate with the same two-cycle alignment.
  - pixel_req is held 0; pixel_data is ignored.
- Undefined: lcd_rgb comes from pixel_data as above.

## Test plan
- ID select: id=0x4342, ID_WAIT=16, reset released → rgb_oe=0 for 17 cycles then 1. Measured: 525 clocks per HS period, HS low 41 clocks, DE high 480 per line, 272 DE lines per 286-line frame.
- Unsupported ID: id=0x0000, then id=0x1234 → fault=1 after CHECK; rgb_oe, lcd_de and lcd_hs stay 0/0/1 indefinitely.
- Alignment: id=0x7084, source returns pixel_data={pixel_y[7:0], pixel_x[7:0], 8'h5A} one cycle after req → first DE cycle of line 0 shows lcd_rgb=0x00005A. The 800th DE cycle shows 0x001F5A (x=799 truncated to 0x1F), coincident with DE.
- ID latch: change id from 0x4342 to 0x7016 during RUN → line period stays 525.
- Mid-frame reset: assert rst for 1 cycle at v_cnt=100 → outputs at reset values next cycle, rgb_oe=0 for ID_WAIT+1 cycles, new frame starts with frame_start.
- Test pattern (macro defined): id=0x1018 → pixel_req stays 0. At pixel (3,5), lcd_rgb=0x030506.
